// File: rtl/min_sort_ctrl_if.sv
// Handshake bundle for the min-sort controller.
//   Upstream:   i_valid / o_ready / i_chi      - unsorted vector in
//   Core:       o_core_chi / i_core_mask       - combinational min-find core
//   Downstream: o_valid / i_ready / o_data / o_idx / o_last - sorted words out
//   Status:     i_abort, o_busy
// Modports: master = the environment (source, sink, core), slave = controller.
// Widths default to the 4x4 configuration; instantiate with the same M/N
// that the controller uses.
interface min_sort_ctrl_if #(
  parameter int M = 4,
  parameter int N = 4
);
  logic                   i_valid;
  logic                   o_ready;
  logic [M-1:0][N-1:0]    i_chi;
  logic                   i_abort;
  logic [M-1:0][N-1:0]    o_core_chi;
  logic [M-1:0]           i_core_mask;
  logic                   o_valid;
  logic                   i_ready;
  logic [N-1:0]           o_data;
  logic [$clog2(M)-1:0]   o_idx;
  logic                   o_last;
  logic                   o_busy;

  modport master (
    output i_valid, i_chi, i_abort, i_core_mask, i_ready,
    input  o_ready, o_core_chi, o_valid, o_data, o_idx, o_last, o_busy
  );

  modport slave (
    input  i_valid, i_chi, i_abort, i_core_mask, i_ready,
    output o_ready, o_core_chi, o_valid, o_data, o_idx, o_last, o_busy
  );
endinterface

// File: rtl/min_sort_ctrl.sv
// Selection-sort controller around an external combinational min-find core.
// A captured vector is emitted one word per handshake in ascending order;
// equal words leave in ascending index order.
// Ports:
//   i_clk, i_rst_n - clock, asynchronous active-low reset
//   bus (slave)    - input vector, core operand/result, sorted output stream
package sort_pkg;
  localparam int M = 4;
  localparam int N = 4;
endpackage

module min_sort_ctrl #(
  parameter int M = sort_pkg::M,
  parameter int N = sort_pkg::N
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  min_sort_ctrl_if.slave bus
);
  localparam int IW = $clog2(M);
  localparam int CW = $clog2(M + 1);

  typedef enum logic [1:0] {IDLE, EVAL, EMIT} state_t;

  state_t              state, state_nx;
  logic [M-1:0][N-1:0] vec;
  logic [M-1:0]        active;
  logic [M-1:0]        sel;
  logic [CW-1:0]       cnt;
  logic [N-1:0]        data_q;
  logic [IW-1:0]       idx_q;
  logic [IW-1:0]       pick;
  logic                last_q;

  // Retired elements are forced to all ones so they never beat a live one.
  // A live all-ones word still ties with them; masking with active below
  // keeps the retired ones from being picked.
  always_comb begin
    for (int k = 0; k < M; k++)
      bus.o_core_chi[k] = active[k] ? vec[k] : {N{1'b1}};
  end

  // Lowest live index among the minima gives the stable order.
  always_comb begin
    sel  = bus.i_core_mask & active;
    pick = '0;
    for (int k = M - 1; k >= 0; k--)
      if (sel[k]) pick = IW'(k);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    bus.o_ready = 1'b0;
    bus.o_valid = 1'b0;
    bus.o_busy  = 1'b1;
    case (state)
      IDLE: begin
        bus.o_ready = 1'b1;
        bus.o_busy  = 1'b0;
        if (bus.i_valid) state_nx = EVAL;
      end
      EVAL: state_nx = bus.i_abort ? IDLE : EMIT;
      EMIT: begin
        bus.o_valid = 1'b1;
        // abort wins over a same-cycle handshake
        if (bus.i_abort)       state_nx = IDLE;
        else if (bus.i_ready)  state_nx = last_q ? IDLE : EVAL;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.o_data = data_q;
  assign bus.o_idx  = idx_q;
  assign bus.o_last = last_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vec    <= '0;
      active <= '0;
      cnt    <= '0;
      data_q <= '0;
      idx_q  <= '0;
      last_q <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.i_valid) begin
          vec    <= bus.i_chi;
          active <= '1;
          cnt    <= '0;
        end
        EVAL: if (bus.i_abort) begin
          vec    <= '0;
          active <= '0;
          cnt    <= '0;
        end else begin
          data_q <= vec[pick];
          idx_q  <= pick;
          last_q <= (cnt == CW'(M - 1));
        end
        EMIT: if (bus.i_abort) begin
          vec    <= '0;
          active <= '0;
          cnt    <= '0;
        end else if (bus.i_ready) begin
          active[idx_q] <= 1'b0;
          cnt           <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_min_sort_ctrl.sv
module tb_min_sort_ctrl;
  localparam int M = 4;
  localparam int N = 4;

  typedef struct {
    logic [N-1:0] e[M];
    logic [N-1:0] d[M];
    logic [1:0]   x[M];
  } vec_rec_t;

  typedef struct {
    logic [N-1:0] data;
    logic [1:0]   idx;
    logic         last;
  } out_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   hs_cnt = 0;
  out_t exp_q[$];
  vec_rec_t tbl[5];

  min_sort_ctrl_if #(.M(M), .N(N)) bus ();

  min_sort_ctrl #(.M(M), .N(N)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference min-find core.
  always_comb begin
    logic [N-1:0] mn;
    mn = bus.o_core_chi[0];
    for (int k = 1; k < M; k++)
      if (bus.o_core_chi[k] < mn) mn = bus.o_core_chi[k];
    for (int k = 0; k < M; k++)
      bus.i_core_mask[k] = (bus.o_core_chi[k] == mn);
  end

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, req);
    end
  endtask

  // Scoreboard: pop on every accepted output word.
  always @(negedge clk) begin
    if (rst_n && bus.o_valid && bus.i_ready && !bus.i_abort) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_word", 1, 0);
      end else begin
        out_t e;
        e = exp_q.pop_front();
        chk("data", int'(bus.o_data), int'(e.data));
        chk("idx",  int'(bus.o_idx),  int'(e.idx));
        chk("last", int'(bus.o_last), int'(e.last));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a vector, queue the first n expected words, return just after accept.
  task automatic load(input vec_rec_t r, input int n);
    int b;
    for (int k = 0; k < M; k++) bus.i_chi[k] = r.e[k];
    for (int j = 0; j < n; j++) exp_q.push_back('{r.d[j], r.x[j], (j == M - 1)});
    bus.i_valid = 1'b1;
    b = 0;
    @(negedge clk);
    while (!bus.o_ready && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (!bus.o_ready) chk("load_timeout", 0, 1);
    tick();
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_hs(input int target);
    int b;
    b = 0;
    while (hs_cnt < target && b < 100) begin
      tick();
      b++;
    end
    if (hs_cnt < target) chk("hs_timeout", hs_cnt, target);
  endtask

  task automatic wait_done();
    int b;
    b = 0;
    while ((exp_q.size() != 0 || bus.o_busy) && b < 100) begin
      tick();
      b++;
    end
    chk("drain_left", exp_q.size(), 0);
    chk("drain_busy", int'(bus.o_busy), 0);
  endtask

  // Stable ranking model: position = #smaller + #equal-with-lower-index.
  function automatic vec_rec_t model(input logic [N-1:0] e[M]);
    vec_rec_t r;
    r.e = e;
    for (int k = 0; k < M; k++) begin
      int rank;
      rank = 0;
      for (int j = 0; j < M; j++)
        if (e[j] < e[k] || (e[j] == e[k] && j < k)) rank++;
      r.d[rank] = e[k];
      r.x[rank] = 2'(k);
    end
    return r;
  endfunction

  initial begin
    int c, first, base;
    logic [N-1:0] d0;
    logic [1:0]   x0;
    logic [N-1:0] re[M];

    tbl[0].e = '{4'd3, 4'd1, 4'd2, 4'd0};
    tbl[0].d = '{4'd0, 4'd1, 4'd2, 4'd3};
    tbl[0].x = '{2'd3, 2'd1, 2'd2, 2'd0};
    tbl[1].e = '{4'd5, 4'd5, 4'd5, 4'd5};
    tbl[1].d = '{4'd5, 4'd5, 4'd5, 4'd5};
    tbl[1].x = '{2'd0, 2'd1, 2'd2, 2'd3};
    tbl[2].e = '{4'hF, 4'hF, 4'h0, 4'hF};
    tbl[2].d = '{4'h0, 4'hF, 4'hF, 4'hF};
    tbl[2].x = '{2'd2, 2'd0, 2'd1, 2'd3};
    tbl[3].e = '{4'd2, 4'd0, 4'd1, 4'd3};
    tbl[3].d = '{4'd0, 4'd1, 4'd2, 4'd3};
    tbl[3].x = '{2'd1, 2'd2, 2'd0, 2'd3};
    tbl[4].e = '{4'hF, 4'hF, 4'hF, 4'hF};
    tbl[4].d = '{4'hF, 4'hF, 4'hF, 4'hF};
    tbl[4].x = '{2'd0, 2'd1, 2'd2, 2'd3};

    rst_n       = 1'b0;
    bus.i_valid = 1'b0;
    bus.i_chi   = '0;
    bus.i_abort = 1'b0;
    bus.i_ready = 1'b1;

    #12;
    chk("rst_valid", int'(bus.o_valid), 0);
    chk("rst_ready", int'(bus.o_ready), 1);
    chk("rst_busy",  int'(bus.o_busy),  0);
    chk("rst_last",  int'(bus.o_last),  0);
    chk("rst_data",  int'(bus.o_data),  0);
    chk("rst_idx",   int'(bus.o_idx),   0);
    #5 rst_n = 1'b1;
    tick();

    // Table vectors with i_ready held high.
    for (int i = 0; i < 5; i++) begin
      load(tbl[i], M);
      wait_done();
    end

    // Latency: first word two cycles after accept, last word in cycle 2M.
    load(tbl[0], M);
    c = 0;
    first = 0;
    while (c < 20) begin
      @(negedge clk);
      c++;
      if (bus.o_valid && first == 0) first = c;
      if (bus.o_valid && bus.o_last) break;
    end
    chk("lat_first", first, 2);
    chk("lat_total", c, 2 * M);
    tick();
    wait_done();

    // Downstream stall of three cycles on the second word.
    load(tbl[0], M);
    wait_hs(hs_cnt + 1);
    bus.i_ready = 1'b0;
    tick();
    @(negedge clk);
    d0 = bus.o_data;
    x0 = bus.o_idx;
    for (int s = 0; s < 3; s++) begin
      if (s > 0) @(negedge clk);
      chk("stall_valid", int'(bus.o_valid), 1);
      chk("stall_data",  int'(bus.o_data),  int'(d0));
      chk("stall_idx",   int'(bus.o_idx),   int'(x0));
    end
    chk("stall_word", int'(bus.o_idx), 1);
    tick();
    bus.i_ready = 1'b1;
    wait_done();

    // Abort in EVAL after two handshakes, then a fresh vector.
    base = hs_cnt;
    load(tbl[0], 2);
    wait_hs(base + 2);
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    @(negedge clk);
    chk("abort_ready", int'(bus.o_ready), 1);
    chk("abort_busy",  int'(bus.o_busy),  0);
    for (int s = 0; s < 4; s++) begin
      chk("abort_novalid", int'(bus.o_valid), 0);
      @(negedge clk);
    end
    tick();
    load(tbl[3], M);
    wait_done();

    // Abort in EMIT beats a same-cycle handshake.
    base = hs_cnt;
    load(tbl[2], 1);
    wait_hs(base + 1);
    tick();
    chk("emit_before_abort", int'(bus.o_valid), 1);
    bus.i_abort = 1'b1;
    tick();
    bus.i_abort = 1'b0;
    chk("abort_emit_valid", int'(bus.o_valid), 0);
    chk("abort_emit_ready", int'(bus.o_ready), 1);
    chk("abort_emit_hs", hs_cnt, base + 1);
    wait_done();

    // Asynchronous reset in the middle of EMIT.
    base = hs_cnt;
    load(tbl[0], M);
    wait_hs(base + 1);
    tick();
    chk("pre_rst_valid", int'(bus.o_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", int'(bus.o_valid), 0);
    chk("async_ready", int'(bus.o_ready), 1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy",  int'(bus.o_busy),  0);
    chk("post_rst_ready", int'(bus.o_ready), 1);
    tick();
    load(tbl[1], M);
    wait_done();

    // Random vectors from a narrow range to force ties.
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < M; k++) re[k] = N'($urandom_range(0, 3));
      if (i == 5) re[1] = '1;
      load(model(re), M);
      wait_done();
    end

    chk("final_queue", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/min_sort_ctrl.md
MIN_SORT_CTRL -- requirements
Module: min_sort_ctrl

Interface
REQ-001 Parameter M, default sort_pkg::M, number of words per sort vector.
REQ-002 Parameter N, default sort_pkg::N, word width in bits.
REQ-003 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-004 i_rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-005 i_valid  input  1  input vector valid.
REQ-006 o_ready  output  1  controller can accept a vector.
REQ-007 i_chi  input  [M-1:0][N-1:0]  unsorted vector; word k is element k.
REQ-008 i_abort  input  1  synchronous abort of the current sort.
REQ-009 o_core_chi  output  [M-1:0][N-1:0]  operand vector driven to the min-find core.
REQ-010 i_core_mask  input  [M-1:0]  core result; bit k = 1 iff o_core_chi[k] equals the minimum of o_core_chi.
REQ-011 o_valid  output  1  sorted output word valid.
REQ-012 i_ready  input  1  downstream accepts the output word.
REQ-013 o_data  output  N  current minimum word.
REQ-014 o_idx  output  $clog2(M)  original index of o_data.
REQ-015 o_last  output  1  o_data is the M-th (final) word of the vector.
REQ-016 o_busy  output  1  state is not IDLE.

Function
REQ-017 The controller SHALL have states IDLE, EVAL and EMIT, plus registers vec (M×N), active (M bits) and cnt ($clog2(M+1) bits).
REQ-018 IDLE: o_ready = 1; when i_valid && o_ready, SHALL capture i_chi into vec, set active to all ones, clear cnt, and go to EVAL.
REQ-019 o_core_chi SHALL be vec with every inactive element replaced by all ones (N'1s); the core is combinational, and its result is sampled in the same cycle.
REQ-020 EVAL: sel = i_core_mask & active; the controller SHALL pick the lowest set index of sel, register o_data = vec[idx], o_idx = idx, o_last = (cnt == M-1), and go to EMIT.
REQ-021 sel SHALL never be zero in EVAL; ties SHALL be emitted in ascending index order (stable sort).
REQ-022 EMIT: o_valid = 1; o_data, o_idx and o_last SHALL hold stable until i_valid-independent handshake o_valid && i_ready.
REQ-023 On the EMIT handshake the controller SHALL clear active[o_idx] and increment cnt; if o_last, it goes to IDLE, else to EVAL.
REQ-024 Latency: input accepted at edge t -> first o_valid in cycle t+2; after each output handshake at edge k, the next o_valid is in cycle k+2; the full vector completes in 2M cycles with i_ready held at 1.
REQ-025 o_ready SHALL be 0 outside IDLE; a new vector is accepted in the cycle after the last handshake at the earliest.
REQ-026 i_abort in EVAL or EMIT SHALL go to IDLE at the next edge, drop o_valid, and discard vec; i_abort has priority over the handshake in the same cycle; in IDLE it has no effect.
REQ-027 o_valid SHALL be 0 in IDLE and EVAL; o_busy = 1 in EVAL and EMIT.
REQ-028 Elements equal to all ones SHALL sort correctly and tie with retired elements; masking with active resolves this.

Reset
REQ-029 Reset asserted at any time SHALL force IDLE immediately: o_valid = 0, o_ready = 1 (while in reset), o_busy = 0, o_last = 0, o_data = 0, o_idx = 0, active = 0, cnt = 0, vec = 0.
REQ-030 After deassertion, the first accepted vector SHALL behave exactly as in REQ-018..REQ-024; no partial sort survives.

Verification (M=4, N=4, reference core model)
REQ-031 Load {e0..e3} = {3,1,2,0}, i_ready = 1 -> outputs (data, idx) = (0,3),(1,1),(2,2),(3,0); o_last only on the 4th; 8 cycles total.
REQ-032 Load {5,5,5,5} -> idx 0,1,2,3, all with data 5.
REQ-033 Load {F,F,0,F} -> (0,2),(F,0),(F,1),(F,3).
REQ-034 Hold i_ready = 0 for 3 cycles during the 2nd word -> o_valid stays 1, and o_data/o_idx stay stable; the sequence is otherwise unchanged.
REQ-035 i_abort after 2 handshakes -> next cycle IDLE, o_ready = 1, no further o_valid; a new vector {2,0,1,3} sorts correctly.
REQ-036 Assert i_rst_n = 0 mid-EMIT between clock edges -> o_valid falls without waiting for an edge; after release, o_busy = 0 and o_ready = 1.
